bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// ============================================================================
//  Module   : bus_arbiter
//  Purpose  : Four-requester rotating-priority bus arbiter with a hold limit
//             and a shared 8-bit data bus multiplexer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [7:0] d0,
  input  logic [7:0] d1,
  input  logic [7:0] d2,
  input  logic [7:0] d3,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic [7:0] bus,
  output logic       bus_valid
);

  localparam logic       c_IDLE      = 1'b0;
  localparam logic       c_GRANT     = 1'b1;
  localparam logic [3:0] c_HOLD_LAST = 4'(MAX_HOLD - 1);

  logic       r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_sel;
  logic [1:0] r_ptr;
  logic [3:0] r_hold;

  logic       w_next_state;
  logic [3:0] w_next_gnt;
  logic [1:0] w_next_sel;
  logic [1:0] w_next_ptr;
  logic [3:0] w_next_hold;
  logic [2:0] w_pick_all;
  logic [2:0] w_pick_oth;

  // Returns {found, index} of the first set mask bit scanning ptr, ptr+1, ...
  function automatic logic [2:0] f_pick(input logic [3:0] i_mask, input logic [1:0] i_ptr);
    logic [1:0] w_idx;
    f_pick = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      w_idx = i_ptr + 2'(i);
      if (i_mask[w_idx]) f_pick = {1'b1, w_idx};
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'b00;
      r_ptr   <= 2'b00;
      r_hold  <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_gnt   <= w_next_gnt;
      r_sel   <= w_next_sel;
      r_ptr   <= w_next_ptr;
      r_hold  <= w_next_hold;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_gnt   = r_gnt;
    w_next_sel   = r_sel;
    w_next_ptr   = r_ptr;
    w_next_hold  = r_hold;
    w_pick_all   = f_pick(req, r_ptr);
    // The current owner is masked out so a hold-limit rotation never re-picks it.
    w_pick_oth   = f_pick(req & ~r_gnt, r_ptr);

    case (r_state)
      c_IDLE: begin
        if (w_pick_all[2]) begin
          w_next_state = c_GRANT;
          w_next_gnt   = 4'b0001 << w_pick_all[1:0];
          w_next_sel   = w_pick_all[1:0];
          w_next_ptr   = w_pick_all[1:0] + 2'd1;
          w_next_hold  = 4'd0;
        end
      end
      default: begin
        if (!req[r_sel] || (r_hold == c_HOLD_LAST)) begin
          if (w_pick_oth[2]) begin
            w_next_gnt  = 4'b0001 << w_pick_oth[1:0];
            w_next_sel  = w_pick_oth[1:0];
            w_next_ptr  = w_pick_oth[1:0] + 2'd1;
            w_next_hold = 4'd0;
          end else if (!req[r_sel]) begin
            w_next_state = c_IDLE;
            w_next_gnt   = 4'b0000;
            w_next_sel   = 2'b00;
            w_next_hold  = 4'd0;
          end else begin
            w_next_hold = 4'd0;
          end
        end else begin
          w_next_hold = r_hold + 4'd1;
        end
      end
    endcase
  end

  always_comb begin
    gnt       = r_gnt;
    sel       = r_sel;
    bus_valid = |r_gnt;
    bus       = 8'h00;
    if (bus_valid) begin
      case (r_sel)
        2'd0:    bus = d0;
        2'd1:    bus = d1;
        2'd2:    bus = d2;
        default: bus = d3;
      endcase
    end
  end

endmodule

`default_nettype wire
